// File: rtl/msg_scheduler_if.sv
// Message-word input and schedule-word output bundle of msg_scheduler.
// slave is the scheduler side; master is the producer/consumer side.
interface msg_scheduler_if;
    logic        valid_i;
    logic [31:0] m_i;
    logic        ovr_clr_i;
    logic        w_valid_o;
    logic [31:0] w_o;
    logic [5:0]  t_o;
    logic        last_o;
    logic        busy_o;
    logic        ovr_err_o;

    modport master (
        output valid_i, m_i, ovr_clr_i,
        input  w_valid_o, w_o, t_o, last_o, busy_o, ovr_err_o
    );

    modport slave (
        input  valid_i, m_i, ovr_clr_i,
        output w_valid_o, w_o, t_o, last_o, busy_o, ovr_err_o
    );
endinterface

// File: rtl/msg_scheduler.sv
// SHA-256 message schedule: loads M0..M15 into a 16-word circular window, then expands W16..W63.
// Define MSG_SCHED_OVR_ERR_EN to flag words offered while expanding in a sticky ovr_err_o.
module msg_scheduler (
    input logic          clk,
    input logic          rst,
    msg_scheduler_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StExpand} state_e;

    state_e      state_q, state_d;
    logic [5:0]  t_q, t_d;          // index of the next word to accept or generate
    logic [31:0] win_q [16];
    logic        win_we;
    logic [31:0] win_wdata;
    logic        w_valid_q, w_valid_d;
    logic [31:0] w_q, w_d;
    logic [5:0]  t_out_q, t_out_d;
    logic        last_q, last_d;
    logic [31:0] w_new;
    logic [3:0]  idx;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Slot t mod 16 still holds W[t-16]; it is overwritten by W[t] on the same edge.
    assign idx   = t_q[3:0];
    assign w_new = sig1(win_q[idx - 4'd2]) + win_q[idx - 4'd7]
                 + sig0(win_q[idx + 4'd1]) + win_q[idx];

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        win_we    = 1'b0;
        win_wdata = bus.m_i;
        w_valid_d = 1'b0;
        w_d       = w_q;
        t_out_d   = t_out_q;
        last_d    = 1'b0;
        unique case (state_q)
            StIdle, StLoad: begin
                if (bus.valid_i) begin
                    win_we    = 1'b1;
                    win_wdata = bus.m_i;
                    w_valid_d = 1'b1;
                    w_d       = bus.m_i;
                    t_out_d   = t_q;
                    t_d       = t_q + 6'd1;
                    state_d   = (t_q == 6'd15) ? StExpand : StLoad;
                end
            end
            StExpand: begin
                win_we    = 1'b1;
                win_wdata = w_new;
                w_valid_d = 1'b1;
                w_d       = w_new;
                t_out_d   = t_q;
                last_d    = (t_q == 6'd63);
                t_d       = t_q + 6'd1;
                if (t_q == 6'd63) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                t_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_q       <= '0;
            w_valid_q <= 1'b0;
            w_q       <= '0;
            t_out_q   <= '0;
            last_q    <= 1'b0;
        end else begin
            t_q       <= t_d;
            w_valid_q <= w_valid_d;
            w_q       <= w_d;
            t_out_q   <= t_out_d;
            last_q    <= last_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else if (win_we) begin
            win_q[idx] <= win_wdata;
        end
    end

    assign bus.w_valid_o = w_valid_q;
    assign bus.w_o       = w_q;
    assign bus.t_o       = t_out_q;
    assign bus.last_o    = last_q;
    assign bus.busy_o    = (state_q == StExpand);

`ifdef MSG_SCHED_OVR_ERR_EN
    logic ovr_q;

    // A word arriving while expanding takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_q <= 1'b0;
        end else if (bus.valid_i && (state_q == StExpand)) begin
            ovr_q <= 1'b1;
        end else if (bus.ovr_clr_i) begin
            ovr_q <= 1'b0;
        end
    end

    assign bus.ovr_err_o = ovr_q;
`else
    logic unused_ovr_clr;

    assign unused_ovr_clr = bus.ovr_clr_i;
    assign bus.ovr_err_o  = 1'b0;
`endif

endmodule
